cvxif_copro_responder: RTL and testbench

// - Coprocessor-side (responder) end of the CV-X-IF used by cv32a65x-class cores (CvxifEn=1, XLEN=32, 4 scoreboard entries).
// - Decodes custom-3 instructions and answers issue requests with accept/writeback.
// - Tracks each offloaded instruction until the core commits or kills it.
// - Returns results to the core in commit order.
// - Sits beside the core; default reference coprocessor for bring-up and CV-X-IF compliance runs.

---
 rtl/cvxif_copro_pkg.sv | 40 ++++
 rtl/cvxif_copro_decoder.sv | 31 +++
 rtl/cvxif_copro_responder.sv | 197 +++++++++++++++++++
 tb/tb_cvxif_copro_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvxif_copro_pkg.sv
// Shared types and constants for the CV-X-IF reference coprocessor responder.
package cvxif_copro_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned NR_ENTRIES      = 4;
  localparam int unsigned ID_WIDTH        = 2;
  localparam int unsigned MULTI_CYCLE_LAT = 3;

  localparam logic [6:0] OPCODE_CUSTOM3  = 7'h7B;
  localparam logic [2:0] FUNCT3_CUS      = 3'b000;
  localparam logic [6:0] FUNCT7_ADD      = 7'h00;
  localparam logic [6:0] FUNCT7_ADD_MULT = 7'h01;
  localparam logic [6:0] FUNCT7_NOP      = 7'h02;

  typedef enum logic [1:0] {
    CUS_ADD,
    CUS_ADD_MULTI,
    CUS_NOP,
    CUS_ILLEGAL
  } cus_op_e;

  typedef enum logic [1:0] {
    FREE,
    ISSUED,
    COMMITTED
  } entry_state_e;

  typedef struct packed {
    cus_op_e         op;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } entry_t;

  // Ops that produce a register result
  function automatic logic op_writes(input cus_op_e op);
    return (op == CUS_ADD) || (op == CUS_ADD_MULTI);
  endfunction

endpackage

// File: rtl/cvxif_copro_decoder.sv
// Combinational custom-3 decoder: instruction word to accept/writeback/op/rd.
module cvxif_copro_decoder
  import cvxif_copro_pkg::*;
(
  input  logic [31:0] instr,
  output logic        accept_c,
  output logic        writeback_c,
  output cus_op_e     op_c,
  output logic [4:0]  rd_c
);

  logic unused_operand_fields;
  assign unused_operand_fields = ^instr[24:15];

  always_comb begin
    op_c = CUS_ILLEGAL;
    if ((instr[6:0] == OPCODE_CUSTOM3) && (instr[14:12] == FUNCT3_CUS)) begin
      case (instr[31:25])
        FUNCT7_ADD:      op_c = CUS_ADD;
        FUNCT7_ADD_MULT: op_c = CUS_ADD_MULTI;
        FUNCT7_NOP:      op_c = CUS_NOP;
        default:         op_c = CUS_ILLEGAL;
      endcase
    end
  end

  assign rd_c        = instr[11:7];
  assign accept_c    = (op_c != CUS_ILLEGAL);
  assign writeback_c = op_writes(op_c);

endmodule

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF coprocessor responder: accepts custom-3 ops, tracks them to commit,
// and returns results in commit order.
module cvxif_copro_responder
  import cvxif_copro_pkg::*;
#(
  parameter int unsigned MultiCycleLat = MULTI_CYCLE_LAT
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [31:0]         issue_instr_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [XLEN-1:0]     issue_rs1_i,
  input  logic [XLEN-1:0]     issue_rs2_i,
  output logic                issue_resp_accept_o,
  output logic                issue_resp_writeback_o,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [4:0]          result_rd_o,
  output logic                result_we_o,
  output logic [XLEN-1:0]     result_data_o
);

  localparam int unsigned CNT_W   = $clog2(MultiCycleLat + 1);
  localparam int unsigned FIFO_CW = ID_WIDTH + 1;

  localparam logic [1:0] EXEC_IDLE = 2'd0;
  localparam logic [1:0] EXEC_BUSY = 2'd1;
  localparam logic [1:0] EXEC_RESP = 2'd2;

  entry_state_e state_q [NR_ENTRIES];
  entry_t       entry_q [NR_ENTRIES];

  logic          dec_accept_c;
  logic          dec_writeback_c;
  cus_op_e       dec_op_c;
  logic [4:0]    dec_rd_c;

  cvxif_copro_decoder u_decoder (
    .instr       (issue_instr_i),
    .accept_c    (dec_accept_c),
    .writeback_c (dec_writeback_c),
    .op_c        (dec_op_c),
    .rd_c        (dec_rd_c)
  );

  assign issue_ready_o          = (state_q[issue_id_i] == FREE);
  assign issue_resp_accept_o    = dec_accept_c;
  assign issue_resp_writeback_o = dec_writeback_c;

  logic issue_fire_c;
  logic commit_act_c;
  logic commit_free_c;
  logic push_c;
  logic pop_c;
  logic result_fire_c;

  assign issue_fire_c  = issue_valid_i && issue_ready_o && dec_accept_c;
  assign commit_act_c  = commit_valid_i && (state_q[commit_id_i] == ISSUED);
  assign commit_free_c = commit_kill_i || !op_writes(entry_q[commit_id_i].op);
  assign push_c        = commit_act_c && !commit_free_c;
  assign result_fire_c = result_valid_o && result_ready_i;

  // Entry table; issue, commit and result always touch distinct ids
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        state_q[i] <= FREE;
        entry_q[i] <= '0;
      end
    end else begin
      if (issue_fire_c) begin
        state_q[issue_id_i] <= ISSUED;
        entry_q[issue_id_i] <= '{op: dec_op_c, rd: dec_rd_c,
                                 rs1: issue_rs1_i, rs2: issue_rs2_i};
      end
      if (commit_act_c) begin
        state_q[commit_id_i] <= commit_free_c ? FREE : COMMITTED;
      end
      if (result_fire_c) begin
        state_q[result_id_o] <= FREE;
      end
    end
  end

  // Commit-order FIFO of ids; depth equals entry count so it cannot overflow
  logic [ID_WIDTH-1:0] fifo_q [NR_ENTRIES];
  logic [ID_WIDTH-1:0] wr_ptr_q;
  logic [ID_WIDTH-1:0] rd_ptr_q;
  logic [FIFO_CW-1:0]  count_q;
  logic                fifo_empty_c;
  logic [ID_WIDTH-1:0] head_id_c;

  assign fifo_empty_c = (count_q == '0);
  assign head_id_c    = fifo_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_ENTRIES; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        fifo_q[wr_ptr_q] <= commit_id_i;
        wr_ptr_q         <= wr_ptr_q + ID_WIDTH'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + ID_WIDTH'(1);
      count_q <= count_q + FIFO_CW'(push_c) - FIFO_CW'(pop_c);
    end
  end

  logic [1:0]       exec_q;
  logic [1:0]       exec_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] head_lat_c;

  assign head_lat_c = (entry_q[head_id_c].op == CUS_ADD_MULTI) ?
                      CNT_W'(MultiCycleLat) : CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      exec_q <= EXEC_IDLE;
      cnt_q  <= '0;
    end else begin
      exec_q <= exec_d;
      cnt_q  <= cnt_d;
    end
  end

  // Exec next-state; a pop loads the counter from the head op's latency
  always_comb begin
    exec_d = exec_q;
    cnt_d  = cnt_q;
    pop_c  = 1'b0;
    case (exec_q)
      EXEC_IDLE: pop_c = !fifo_empty_c;
      EXEC_BUSY: begin
        if (cnt_q <= CNT_W'(1)) begin
          exec_d = EXEC_RESP;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      EXEC_RESP: begin
        if (result_ready_i) begin
          exec_d = EXEC_IDLE;
          pop_c  = !fifo_empty_c;
        end
      end
      default: exec_d = EXEC_IDLE;
    endcase
    if (pop_c) begin
      if (head_lat_c == CNT_W'(1)) begin
        exec_d = EXEC_RESP;
        cnt_d  = '0;
      end else begin
        exec_d = EXEC_BUSY;
        cnt_d  = head_lat_c - CNT_W'(1);
      end
    end
  end

  // Result payload is captured at pop and held until the handshake
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
      result_rd_o    <= '0;
      result_we_o    <= 1'b0;
      result_data_o  <= '0;
    end else begin
      result_valid_o <= (exec_d == EXEC_RESP);
      if (pop_c) begin
        result_id_o   <= head_id_c;
        result_rd_o   <= entry_q[head_id_c].rd;
        result_we_o   <= 1'b1;
        result_data_o <= entry_q[head_id_c].rs1 + entry_q[head_id_c].rs2;
      end
    end
  end

`ifndef SYNTHESIS
  commit_targets_issued_a : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    commit_valid_i |-> (state_q[commit_id_i] == ISSUED)
  );
`endif

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Directed self-checking bench for cvxif_copro_responder.
module tb_cvxif_copro_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [31:0] issue_instr_i;
  logic [1:0]  issue_id_i;
  logic [31:0] issue_rs1_i;
  logic [31:0] issue_rs2_i;
  logic        issue_resp_accept_o;
  logic        issue_resp_writeback_o;
  logic        commit_valid_i;
  logic [1:0]  commit_id_i;
  logic        commit_kill_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [1:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;
  logic [31:0] result_data_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  cvxif_copro_responder dut (
    .clk_i                  (clk_i),
    .rst_ni                 (rst_ni),
    .issue_valid_i          (issue_valid_i),
    .issue_ready_o          (issue_ready_o),
    .issue_instr_i          (issue_instr_i),
    .issue_id_i             (issue_id_i),
    .issue_rs1_i            (issue_rs1_i),
    .issue_rs2_i            (issue_rs2_i),
    .issue_resp_accept_o    (issue_resp_accept_o),
    .issue_resp_writeback_o (issue_resp_writeback_o),
    .commit_valid_i         (commit_valid_i),
    .commit_id_i            (commit_id_i),
    .commit_kill_i          (commit_kill_i),
    .result_valid_o         (result_valid_o),
    .result_ready_i         (result_ready_i),
    .result_id_o            (result_id_o),
    .result_rd_o            (result_rd_o),
    .result_we_o            (result_we_o),
    .result_data_o          (result_data_o)
  );

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rd);
    enc = {f7, 10'd0, 3'b000, rd, 7'h7B};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_issue(input logic [1:0] id, input logic [6:0] f7,
                             input logic [4:0] rd, input logic [31:0] a,
                             input logic [31:0] b);
    issue_valid_i = 1'b1;
    issue_id_i    = id;
    issue_instr_i = enc(f7, rd);
    issue_rs1_i   = a;
    issue_rs2_i   = b;
    #1;
  endtask

  task automatic do_commit(input logic [1:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
    tick();
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    total++; if (result_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", result_valid_o); end
    total++; if (result_we_o !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", result_we_o); end
    total++; if (result_data_o !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", result_data_o); end
    total++; if (result_id_o !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d exp=0", result_id_o); end
    total++; if (result_rd_o !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d exp=0", result_rd_o); end
    rst_ni = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      issue_id_i = 2'(i);
      #1;
      total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready id=%0d got=%b exp=1", i, issue_ready_o); end
    end
  endtask

  task automatic test_add();
    drive_issue(2'd1, 7'h00, 5'd3, 32'd5, 32'd7);
    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL add_ready got=%b exp=1", issue_ready_o); end
    total++; if (issue_resp_accept_o !== 1'b1) begin bad++; $display("FAIL add_accept got=%b exp=1", issue_resp_accept_o); end
    total++; if (issue_resp_writeback_o !== 1'b1) begin bad++; $display("FAIL add_wb got=%b exp=1", issue_resp_writeback_o); end
    tick();
    issue_valid_i = 1'b0;
    do_commit(2'd1, 1'b0);
    total++; if (result_valid_o !== 1'b0) begin bad++; $display("FAIL add_early_valid got=%b exp=0", result_valid_o); end
    tick();
    total++; if (result_valid_o !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", result_valid_o); end
    total++; if (result_id_o !== 2'd1) begin bad++; $display("FAIL add_id got=%0d exp=1", result_id_o); end
    total++; if (result_we_o !== 1'b1) begin bad++; $display("FAIL add_we got=%b exp=1", result_we_o); end
    total++; if (result_data_o !== 32'd12) begin bad++; $display("FAIL add_data got=%h exp=%h", result_data_o, 32'd12); end
    total++; if (result_rd_o !== 5'd3) begin bad++; $display("FAIL add_rd got=%0d exp=3", result_rd_o); end
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    total++; if (result_valid_o !== 1'b0) begin bad++; $display("FAIL add_drop_valid got=%b exp=0", result_valid_o); end
    issue_id_i = 2'd1;
    #1;
    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL add_freed got=%b exp=1", issue_ready_o); end
  endtask

  task automatic test_add_multi();
    drive_issue(2'd0, 7'h01, 5'd9, 32'hFFFF_FFFF, 32'd2);
    total++; if (issue_resp_accept_o !== 1'b1) begin bad++; $display("FAIL multi_accept got=%b exp=1", issue_resp_accept_o); end
    tick();
    issue_valid_i = 1'b0;
    do_commit(2'd0, 1'b0);
    tick();
    tick();
    total++; if (result_valid_o !== 1'b0) begin bad++; $display("FAIL multi_early_valid got=%b exp=0", result_valid_o); end
    tick();
    total++; if (result_valid_o !== 1'b1) begin bad++; $display("FAIL multi_valid got=%b exp=1", result_valid_o); end
    total++; if (result_data_o !== 32'd1) begin bad++; $display("FAIL multi_data got=%h exp=1", result_data_o); end
    total++; if (result_id_o !== 2'd0) begin bad++; $display("FAIL multi_id got=%0d exp=0", result_id_o); end
    total++; if (result_rd_o !== 5'd9) begin bad++; $display("FAIL multi_rd got=%0d exp=9", result_rd_o); end
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    total++; if (result_valid_o !== 1'b0) begin bad++; $display("FAIL multi_drop_valid got=%b exp=0", result_valid_o); end
  endtask

  task automatic test_nop_illegal();
    drive_issue(2'd0, 7'h05, 5'd2, 32'd1, 32'd1);
    total++; if (issue_resp_accept_o !== 1'b0) begin bad++; $display("FAIL illegal_accept got=%b exp=0", issue_resp_accept_o); end
    total++; if (issue_resp_writeback_o !== 1'b0) begin bad++; $display("FAIL illegal_wb got=%b exp=0", issue_resp_writeback_o); end
    tick();
    issue_valid_i = 1'b0;
    #1;
    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL illegal_state got=%b exp=1", issue_ready_o); end
    drive_issue(2'd2, 7'h02, 5'd6, 32'd1, 32'd1);
    total++; if (issue_resp_accept_o !== 1'b1) begin bad++; $display("FAIL nop_accept got=%b exp=1", issue_resp_accept_o); end
    total++; if (issue_resp_writeback_o !== 1'b0) begin bad++; $display("FAIL nop_wb got=%b exp=0", issue_resp_writeback_o); end
    tick();
    issue_valid_i = 1'b0;
    #1;
    total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL nop_busy got=%b exp=0", issue_ready_o); end
    do_commit(2'd2, 1'b0);
    issue_id_i = 2'd2;
    #1;
    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL nop_freed got=%b exp=1", issue_ready_o); end
    tick();
    tick();
    total++; if (result_valid_o !== 1'b0) begin bad++; $display("FAIL nop_result got=%b exp=0", result_valid_o); end
  endtask

  task automatic test_full_kill();
    for (int i = 0; i < 4; i++) begin
      drive_issue(2'(i), 7'h00, 5'(i + 4), 32'(100 * (i + 1)), 32'(i + 1));
      tick();
    end
    drive_issue(2'd1, 7'h00, 5'd1, 32'd0, 32'd0);
    total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", issue_ready_o); end
    issue_valid_i = 1'b0;
    do_commit(2'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      issue_id_i = 2'(i);
      #1;
      total++; if (issue_ready_o !== (i == 2)) begin bad++; $display("FAIL kill_ready id=%0d got=%b exp=%b", i, issue_ready_o, i == 2); end
    end
    tick();
    tick();
    total++; if (result_valid_o !== 1'b0) begin bad++; $display("FAIL kill_result got=%b exp=0", result_valid_o); end
  endtask

  task automatic test_order_hold();
    logic [1:0]  exp_id  [3];
    logic [31:0] exp_dat [3];
    exp_id[0] = 2'd3; exp_dat[0] = 32'd404;
    exp_id[1] = 2'd0; exp_dat[1] = 32'd101;
    exp_id[2] = 2'd1; exp_dat[2] = 32'd202;
    for (int i = 0; i < 3; i++) begin
      commit_valid_i = 1'b1;
      commit_id_i    = exp_id[i];
      commit_kill_i  = 1'b0;
      tick();
    end
    commit_valid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total++; if (result_valid_o !== 1'b1) begin bad++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", k, result_valid_o); end
      total++; if (result_id_o !== 2'd3) begin bad++; $display("FAIL hold_id cyc=%0d got=%0d exp=3", k, result_id_o); end
      total++; if (result_data_o !== 32'd404) begin bad++; $display("FAIL hold_data cyc=%0d got=%h exp=%h", k, result_data_o, 32'd404); end
      total++; if (result_rd_o !== 5'd7) begin bad++; $display("FAIL hold_rd cyc=%0d got=%0d exp=7", k, result_rd_o); end
      tick();
    end
    result_ready_i = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      total++; if (result_valid_o !== 1'b1) begin bad++; $display("FAIL order_valid n=%0d got=%b exp=1", i, result_valid_o); end
      total++; if (result_id_o !== exp_id[i]) begin bad++; $display("FAIL order_id n=%0d got=%0d exp=%0d", i, result_id_o, exp_id[i]); end
      total++; if (result_data_o !== exp_dat[i]) begin bad++; $display("FAIL order_data n=%0d got=%h exp=%h", i, result_data_o, exp_dat[i]); end
      total++; if (result_we_o !== 1'b1) begin bad++; $display("FAIL order_we n=%0d got=%b exp=1", i, result_we_o); end
    end
    tick();
    result_ready_i = 1'b0;
    total++; if (result_valid_o !== 1'b0) begin bad++; $display("FAIL order_drain got=%b exp=0", result_valid_o); end
    for (int i = 0; i < 4; i++) begin
      issue_id_i = 2'(i);
      #1;
      total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL order_free id=%0d got=%b exp=1", i, issue_ready_o); end
    end
  endtask

  task automatic test_reset_busy();
    drive_issue(2'd3, 7'h01, 5'd1, 32'd3, 32'd4);
    tick();
    issue_valid_i = 1'b0;
    do_commit(2'd3, 1'b0);
    tick();
    rst_ni = 1'b0;
    tick();
    total++; if (result_valid_o !== 1'b0) begin bad++; $display("FAIL rstbusy_valid got=%b exp=0", result_valid_o); end
    total++; if (result_we_o !== 1'b0) begin bad++; $display("FAIL rstbusy_we got=%b exp=0", result_we_o); end
    total++; if (result_data_o !== 32'd0) begin bad++; $display("FAIL rstbusy_data got=%h exp=0", result_data_o); end
    total++; if (result_id_o !== 2'd0) begin bad++; $display("FAIL rstbusy_id got=%0d exp=0", result_id_o); end
    total++; if (result_rd_o !== 5'd0) begin bad++; $display("FAIL rstbusy_rd got=%0d exp=0", result_rd_o); end
    for (int i = 0; i < 4; i++) begin
      issue_id_i = 2'(i);
      #1;
      total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL rstbusy_ready id=%0d got=%b exp=1", i, issue_ready_o); end
    end
    rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (result_valid_o !== 1'b0) begin bad++; $display("FAIL rstbusy_drop cyc=%0d got=%b exp=0", k, result_valid_o); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni         = 1'b0;
    issue_valid_i  = 1'b0;
    issue_instr_i  = 32'd0;
    issue_id_i     = 2'd0;
    issue_rs1_i    = 32'd0;
    issue_rs2_i    = 32'd0;
    commit_valid_i = 1'b0;
    commit_id_i    = 2'd0;
    commit_kill_i  = 1'b0;
    result_ready_i = 1'b0;
    test_reset();
    test_add();
    test_add_multi();
    test_nop_illegal();
    test_full_kill();
    test_order_hold();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
